rvc_asap_5pl_lsu: RTL and testbench
===================================

Name: rvc_asap_5pl_lsu

Overview:
Load/store unit that sits directly upstream of the memory wrapper in the 5-stage pipeline.
- Q103H: takes the pipeline's load/store request, then drives the wrapper's address, write data, byte-enable, write-enable and read-enable inputs.
- Q104H: consumes the wrapper's synchronous read data, then lane-shifts, sign/zero-extends and merges it into the writeback value.
- Misaligned accesses are split into two aligned accesses by a small FSM that stalls the pipeline for one cycle.

Parameters:
ADDR_W, 32, address width; bits [1:0] are the byte offset.
WORD_STRIDE, 4, byte increment between the first and second split access.

Ports:
Clock  in  1  core clock
Rst  in  1  asynchronous, active-high reset
ReqValidQ103H  in  1  load or store present in Q103H
ReqWrEnQ103H  in  1  1=store, 0=load
Funct3Q103H  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
AddrQ103H  in  ADDR_W  effective address (ALU result)
StDataQ103H  in  32  store source (rs2)
StallLsu  out  1  hold Q103H and earlier stages this cycle
MemAddr  out  ADDR_W  to wrapper address input
MemWrData  out  32  to wrapper write-data input
MemByteEn  out  4  to wrapper byte-enable input
MemWrEn  out  1  to wrapper write-enable input
MemRdEn  out  1  to wrapper read-select input
MemRdDataQ104H  in  32  wrapper read data, one cycle after MemRdEn
LdDataQ104H  out  32  aligned and extended load result
LdValidQ104H  out  1  LdDataQ104H valid this cycle
MisalignErrQ104H  out  1  misaligned access rejected (feature-off build only)

Behaviour:
Reset:
- Rst is asynchronous, active-high.
- While Rst is asserted: FSM=IDLE; all registered state cleared; every output 0.
- Rst asserted mid-split: the second access is abandoned and no merge result is produced.

Request decode:
- Off = AddrQ103H[1:0].
- Size mask: B=0001, H=0011, W=1111.
- Misaligned when: (H and Off==3) or (W and Off!=0).
- Wide enable = mask<<Off, 8 bits.

FSM state IDLE, aligned request:
- MemAddr = AddrQ103H.
- MemByteEn = Wide[3:0].
- MemWrData = StDataQ103H << 8*Off.
- MemWrEn = ReqWrEnQ103H; MemRdEn = !ReqWrEnQ103H.
- StallLsu = 0.

FSM state IDLE, misaligned request (first access):
- MemAddr = {AddrQ103H[ADDR_W-1:2], 2'b00}, with the same enable/data rule.
- StallLsu = 1; go to SECOND.
- Latch Funct3, Off and ReqWrEn.

FSM state SECOND:
- MemAddr = first aligned address + WORD_STRIDE, wrapping modulo 2^ADDR_W.
- MemByteEn = Wide[7:4].
- MemWrData = StDataQ103H >> 8*(4-Off).
- StallLsu = 0; return to IDLE.
- For loads, capture MemRdDataQ104H (first word) into LowWord.

Idle and cycle timing:
- No request: all Mem* enables 0; MemAddr holds AddrQ103H.
- Aligned access: single cycle.
- Misaligned access: exactly 2 cycles, with 1 stall cycle.

Load return (registered Q103H→Q104H copies of Funct3, Off, RdEn, Merge):
- LdValidQ104H = 1 exactly one cycle after the final read issue of a load; never for stores.
- Aligned: Raw = MemRdDataQ104H >> 8*Off.
- Merged: Raw = ({MemRdDataQ104H, LowWord} >> 8*Off)[31:0].
- Extension: B/H sign-extend Raw[7]/Raw[15]; BU/HU zero-extend; W passes through.
- LdDataQ104H = 0 when LdValidQ104H = 0.

Back-to-back requests:
- A new request may be accepted in the cycle after SECOND; no bubble beyond the single stall.

Optional Feature:
Macro: RVC_LSU_MISALIGN_SPLIT_EN.
- Defined: split behaviour as above; MisalignErrQ104H tied to 0.
- Undefined: no SECOND state and StallLsu is constant 0. A misaligned request instead:
  - suppresses MemWrEn and MemRdEn;
  - next cycle pulses MisalignErrQ104H=1 for one cycle;
  - for a load, also gives LdValidQ104H=1 with LdDataQ104H=0.

Test Plan:
- Aligned LW @0x1000 with mem[0x1000]=0xDEADBEEF → MemRdEn=1, ByteEn=1111, no stall; next cycle LdDataQ104H=0xDEADBEEF, LdValidQ104H=1.
- LB @0x1003 with word 0x80xxxxxx → ByteEn=1000; LdDataQ104H=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH 0xABCD @0x1002 → ByteEn=1100, MemWrData=0xABCD0000, MemWrEn=1 for one cycle; readback LHU → 0x0000ABCD.
- (Split build) LW @0x1001 with mem[0x1000]=0x44332211, mem[0x1004]=0x88776655:
  - StallLsu=1 for one cycle;
  - addresses issued 0x1000 then 0x1004;
  - ByteEn issued 1110 then 0001;
  - LdDataQ104H=0x55443322.
- (Split build) SW 0xA1B2C3D4 @0x1003:
  - writes ByteEn 1000 with data 0xD4000000, then ByteEn 0111 with data 0x00A1B2C3;
  - SW at 0xFFFFFFFE wraps its second access to 0x00000000.
- Rst asserted during SECOND → all outputs 0 immediately; FSM=IDLE; no LdValidQ104H afterwards. Non-split build, LW @0x1002 → no Mem enable; MisalignErrQ104H=1 for one cycle; LdDataQ104H=0.

Source files
------------

// File: rtl/rvc_asap_5pl_lsu.sv
// rvc_asap_5pl_lsu
// Load/store unit sitting between the Q103H pipeline stage and the synchronous
// memory wrapper. In Q103H it issues address, write data, byte enables and the
// write/read enables. In Q104H it lane-shifts, extends and, for split loads,
// merges the wrapper's read data into the writeback value.
//
// Build option: RVC_LSU_MISALIGN_SPLIT_EN
//   defined   - a misaligned access is split into two aligned accesses with a
//               one-cycle stall; MisalignErrQ104H is tied low.
//   undefined - a misaligned access issues nothing and is flagged on
//               MisalignErrQ104H in Q104H; StallLsu is tied low.
//
// Ports:
//   Clock, Rst                core clock, asynchronous active-high reset
//   ReqValidQ103H             load or store present in Q103H
//   ReqWrEnQ103H              1 = store, 0 = load
//   Funct3Q103H               000 B, 001 H, 010 W, 100 BU, 101 HU
//   AddrQ103H, StDataQ103H    effective address and store source
//   StallLsu                  hold Q103H and earlier stages this cycle
//   MemAddr, MemWrData        wrapper address and write data
//   MemByteEn                 wrapper byte enables
//   MemWrEn, MemRdEn          wrapper write / read enables
//   MemRdDataQ104H            wrapper read data, one cycle after MemRdEn
//   LdDataQ104H, LdValidQ104H aligned and extended load result
//   MisalignErrQ104H          misaligned access rejected (non-split build)
//
// state  | meaning
// IDLE   | accepting requests; aligned accesses complete here
// SECOND | second aligned half of a split access (split build only)

module rvc_asap_5pl_lsu #(
    parameter int ADDR_W      = 32,
    parameter int WORD_STRIDE = 4
) (
    input  logic              Clock,
    input  logic              Rst,
    input  logic              ReqValidQ103H,
    input  logic              ReqWrEnQ103H,
    input  logic [2:0]        Funct3Q103H,
    input  logic [ADDR_W-1:0] AddrQ103H,
    input  logic [31:0]       StDataQ103H,
    output logic              StallLsu,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWrData,
    output logic [3:0]        MemByteEn,
    output logic              MemWrEn,
    output logic              MemRdEn,
    input  logic [31:0]       MemRdDataQ104H,
    output logic [31:0]       LdDataQ104H,
    output logic              LdValidQ104H,
    output logic              MisalignErrQ104H
);

    // The second half of a split access has to land on a word boundary.
    if ((WORD_STRIDE % 4) != 0) begin : g_stride_check
        $error("WORD_STRIDE must be a multiple of 4");
    end

    logic [1:0]  req_off;
    logic [3:0]  size_mask;
    logic [7:0]  wide_en;
    logic        misaligned;
    logic [31:0] st_data_lo;

    logic [2:0]  q104_funct3;
    logic [1:0]  q104_off;
    logic        q104_ld_valid;
    logic        q104_merge;
    logic        q104_err;
    logic [31:0] low_word;
    logic [31:0] ld_raw;
    logic [31:0] ld_ext;

    assign req_off = AddrQ103H[1:0];

    always_comb begin
        case (Funct3Q103H[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    // An access is misaligned exactly when its enables spill into the next word.
    assign wide_en    = {4'b0000, size_mask} << req_off;
    assign misaligned = |wide_en[7:4];
    assign st_data_lo = StDataQ103H << {req_off, 3'b000};

`ifdef RVC_LSU_MISALIGN_SPLIT_EN
    typedef enum logic {IDLE, SECOND} state_t;

    state_t            state;
    logic [2:0]        lat_funct3;
    logic [1:0]        lat_off;
    logic              lat_wr_en;
    logic [3:0]        lat_en_hi;
    logic [ADDR_W-1:0] lat_base;

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            state         <= IDLE;
            lat_funct3    <= '0;
            lat_off       <= '0;
            lat_wr_en     <= 1'b0;
            lat_en_hi     <= '0;
            lat_base      <= '0;
            low_word      <= '0;
            q104_funct3   <= '0;
            q104_off      <= '0;
            q104_ld_valid <= 1'b0;
            q104_merge    <= 1'b0;
        end else begin
            q104_ld_valid <= 1'b0;
            q104_merge    <= 1'b0;
            case (state)
                IDLE: begin
                    if (ReqValidQ103H) begin
                        if (misaligned) begin
                            state      <= SECOND;
                            lat_funct3 <= Funct3Q103H;
                            lat_off    <= req_off;
                            lat_wr_en  <= ReqWrEnQ103H;
                            lat_en_hi  <= wide_en[7:4];
                            lat_base   <= {AddrQ103H[ADDR_W-1:2], 2'b00};
                        end else begin
                            q104_funct3   <= Funct3Q103H;
                            q104_off      <= req_off;
                            q104_ld_valid <= !ReqWrEnQ103H;
                        end
                    end
                end
                SECOND: begin
                    state <= IDLE;
                    // Read data arriving now belongs to the first (low) word.
                    if (!lat_wr_en) begin
                        low_word      <= MemRdDataQ104H;
                        q104_funct3   <= lat_funct3;
                        q104_off      <= lat_off;
                        q104_ld_valid <= 1'b1;
                        q104_merge    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign q104_err = 1'b0;

    always_comb begin
        StallLsu  = 1'b0;
        MemAddr   = AddrQ103H;
        MemWrData = '0;
        MemByteEn = '0;
        MemWrEn   = 1'b0;
        MemRdEn   = 1'b0;
        if (Rst) begin
            MemAddr = '0;
        end else if (state == SECOND) begin
            MemAddr   = lat_base + ADDR_W'(WORD_STRIDE);
            MemByteEn = lat_en_hi;
            MemWrData = StDataQ103H >> {(3'd4 - {1'b0, lat_off}), 3'b000};
            MemWrEn   = lat_wr_en;
            MemRdEn   = !lat_wr_en;
        end else if (ReqValidQ103H) begin
            MemByteEn = wide_en[3:0];
            MemWrData = st_data_lo;
            MemWrEn   = ReqWrEnQ103H;
            MemRdEn   = !ReqWrEnQ103H;
            if (misaligned) begin
                MemAddr  = {AddrQ103H[ADDR_W-1:2], 2'b00};
                StallLsu = 1'b1;
            end
        end
    end
`else
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            q104_funct3   <= '0;
            q104_off      <= '0;
            q104_ld_valid <= 1'b0;
            q104_err      <= 1'b0;
        end else begin
            q104_ld_valid <= ReqValidQ103H && !ReqWrEnQ103H;
            q104_err      <= ReqValidQ103H && misaligned;
            if (ReqValidQ103H) begin
                q104_funct3 <= Funct3Q103H;
                q104_off    <= req_off;
            end
        end
    end

    assign q104_merge = 1'b0;
    assign low_word   = '0;

    always_comb begin
        StallLsu  = 1'b0;
        MemAddr   = AddrQ103H;
        MemWrData = '0;
        MemByteEn = '0;
        MemWrEn   = 1'b0;
        MemRdEn   = 1'b0;
        if (Rst) begin
            MemAddr = '0;
        end else if (ReqValidQ103H && !misaligned) begin
            MemByteEn = wide_en[3:0];
            MemWrData = st_data_lo;
            MemWrEn   = ReqWrEnQ103H;
            MemRdEn   = !ReqWrEnQ103H;
        end
    end
`endif

    // Split loads shift across the {high, low} word pair.
    assign ld_raw = 32'((q104_merge ? {MemRdDataQ104H, low_word}
                                    : {32'h0000_0000, MemRdDataQ104H}) >> {q104_off, 3'b000});

    always_comb begin
        case (q104_funct3)
            3'b000:  ld_ext = {{24{ld_raw[7]}}, ld_raw[7:0]};
            3'b001:  ld_ext = {{16{ld_raw[15]}}, ld_raw[15:0]};
            3'b100:  ld_ext = {24'h000000, ld_raw[7:0]};
            3'b101:  ld_ext = {16'h0000, ld_raw[15:0]};
            default: ld_ext = ld_raw;
        endcase
    end

    assign LdValidQ104H     = q104_ld_valid;
    assign LdDataQ104H      = (q104_ld_valid && !q104_err) ? ld_ext : '0;
    assign MisalignErrQ104H = q104_err;

endmodule

// File: tb/tb_rvc_asap_5pl_lsu.sv
module tb_rvc_asap_5pl_lsu;

    logic        Clock = 1'b0;
    logic        Rst = 1'b1;
    logic        ReqValidQ103H = 1'b0;
    logic        ReqWrEnQ103H = 1'b0;
    logic [2:0]  Funct3Q103H = 3'b000;
    logic [31:0] AddrQ103H = '0;
    logic [31:0] StDataQ103H = '0;
    logic        StallLsu;
    logic [31:0] MemAddr;
    logic [31:0] MemWrData;
    logic [3:0]  MemByteEn;
    logic        MemWrEn;
    logic        MemRdEn;
    logic [31:0] MemRdDataQ104H;
    logic [31:0] LdDataQ104H;
    logic        LdValidQ104H;
    logic        MisalignErrQ104H;

    logic [31:0] mem [16];
    logic [31:0] rd_q = '0;
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    int n_cmp = 0;
    int n_bad = 0;

    // ctl = {stall, wr_en, rd_en, byte_en}; ret = {ld_valid, err, ld_data}
    logic [6:0]  ctl;
    logic [33:0] ret;
    assign ctl = {StallLsu, MemWrEn, MemRdEn, MemByteEn};
    assign ret = {LdValidQ104H, MisalignErrQ104H, LdDataQ104H};

    always #5 Clock = ~Clock;

    rvc_asap_5pl_lsu #(.ADDR_W(32), .WORD_STRIDE(4)) dut (
        .Clock(Clock),
        .Rst(Rst),
        .ReqValidQ103H(ReqValidQ103H),
        .ReqWrEnQ103H(ReqWrEnQ103H),
        .Funct3Q103H(Funct3Q103H),
        .AddrQ103H(AddrQ103H),
        .StDataQ103H(StDataQ103H),
        .StallLsu(StallLsu),
        .MemAddr(MemAddr),
        .MemWrData(MemWrData),
        .MemByteEn(MemByteEn),
        .MemWrEn(MemWrEn),
        .MemRdEn(MemRdEn),
        .MemRdDataQ104H(MemRdDataQ104H),
        .LdDataQ104H(LdDataQ104H),
        .LdValidQ104H(LdValidQ104H),
        .MisalignErrQ104H(MisalignErrQ104H)
    );

    // Synchronous memory wrapper: 16 words indexed by address bits [5:2].
    assign MemRdDataQ104H = rd_q;
    always @(posedge Clock) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        if (MemWrEn) begin
            for (int b = 0; b < 4; b++)
                if (MemByteEn[b]) mem[MemAddr[5:2]][8*b +: 8] <= MemWrData[8*b +: 8];
        end
        if (MemRdEn) rd_q <= mem[MemAddr[5:2]];
    end

    task automatic drive_req(input logic v, input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d);
        @(negedge Clock);
        ReqValidQ103H = v;
        ReqWrEnQ103H  = we;
        Funct3Q103H   = f3;
        AddrQ103H     = a;
        StDataQ103H   = d;
        #1;
    endtask

    task automatic hold_cycle();
        @(negedge Clock);
        #1;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] w);
        @(negedge Clock);
        ReqValidQ103H = 1'b0;
        pl_en   = 1'b1;
        pl_idx  = idx;
        pl_data = w;
        @(posedge Clock);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        ReqValidQ103H = 1'b1;
        ReqWrEnQ103H  = 1'b0;
        Funct3Q103H   = 3'b010;
        AddrQ103H     = 32'h0000_1000;
        StDataQ103H   = 32'hFFFF_FFFF;
        #12;
        n_cmp++;
        if ({ctl, MemAddr, MemWrData, ret} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ctl=%b addr=%h wd=%h ret=%h expected all zero",
                     ctl, MemAddr, MemWrData, ret);
        end
        @(negedge Clock);
        ReqValidQ103H = 1'b0;
        Rst = 1'b0;
    endtask

    task automatic test_aligned_lw();
        preload(4'd0, 32'hDEAD_BEEF);
        drive_req(1, 0, 3'b010, 32'h0000_1000, 0);
        n_cmp++;
        if ({ctl, MemAddr} !== {7'b0011111, 32'h0000_1000}) begin
            n_bad++;
            $display("FAIL lw_issue: got ctl=%b addr=%h expected ctl=0011111 addr=00001000", ctl, MemAddr);
        end
        drive_req(0, 0, 3'b000, 32'h0000_1000, 0);
        n_cmp++;
        if (ret !== {2'b10, 32'hDEAD_BEEF}) begin
            n_bad++;
            $display("FAIL lw_return: got %h expected %h", ret, {2'b10, 32'hDEAD_BEEF});
        end
        drive_req(0, 0, 3'b000, 32'h0000_1000, 0);
        n_cmp++;
        if (ret !== '0) begin
            n_bad++;
            $display("FAIL lw_valid_drop: got %h expected 0", ret);
        end
    endtask

    task automatic test_byte_load();
        preload(4'd0, 32'h80A1_B2C3);
        drive_req(1, 0, 3'b000, 32'h0000_1003, 0);
        n_cmp++;
        if ({ctl, MemAddr} !== {7'b0011000, 32'h0000_1003}) begin
            n_bad++;
            $display("FAIL lb_issue: got ctl=%b addr=%h expected ctl=0011000 addr=00001003", ctl, MemAddr);
        end
        drive_req(1, 0, 3'b100, 32'h0000_1003, 0);
        n_cmp++;
        if (ret !== {2'b10, 32'hFFFF_FF80}) begin
            n_bad++;
            $display("FAIL lb_sign: got %h expected %h", ret, {2'b10, 32'hFFFF_FF80});
        end
        drive_req(1, 0, 3'b001, 32'h0000_1000, 0);
        n_cmp++;
        if (ret !== {2'b10, 32'h0000_0080}) begin
            n_bad++;
            $display("FAIL lbu_zero: got %h expected %h", ret, {2'b10, 32'h0000_0080});
        end
        n_cmp++;
        if (ctl !== 7'b0010011) begin
            n_bad++;
            $display("FAIL lh_issue: got ctl=%b expected 0010011", ctl);
        end
        drive_req(0, 0, 3'b000, 32'h0000_1000, 0);
        n_cmp++;
        if (ret !== {2'b10, 32'hFFFF_B2C3}) begin
            n_bad++;
            $display("FAIL lh_sign: got %h expected %h", ret, {2'b10, 32'hFFFF_B2C3});
        end
    endtask

    task automatic test_store_half();
        drive_req(1, 1, 3'b001, 32'h0000_1002, 32'h5555_ABCD);
        n_cmp++;
        if ({ctl, MemWrData} !== {7'b0101100, 32'hABCD_0000}) begin
            n_bad++;
            $display("FAIL sh_issue: got ctl=%b wd=%h expected ctl=0101100 wd=abcd0000", ctl, MemWrData);
        end
        drive_req(1, 0, 3'b101, 32'h0000_1002, 0);
        n_cmp++;
        if (ret !== '0) begin
            n_bad++;
            $display("FAIL sh_no_ldvalid: got %h expected 0", ret);
        end
        n_cmp++;
        if (ctl !== 7'b0011100) begin
            n_bad++;
            $display("FAIL lhu_issue: got ctl=%b expected 0011100", ctl);
        end
        drive_req(1, 0, 3'b001, 32'h0000_1002, 0);
        n_cmp++;
        if (ret !== {2'b10, 32'h0000_ABCD}) begin
            n_bad++;
            $display("FAIL sh_readback_lhu: got %h expected %h", ret, {2'b10, 32'h0000_ABCD});
        end
        drive_req(0, 0, 3'b000, 32'h0000_1002, 0);
        n_cmp++;
        if (ret !== {2'b10, 32'hFFFF_ABCD}) begin
            n_bad++;
            $display("FAIL sh_readback_lh: got %h expected %h", ret, {2'b10, 32'hFFFF_ABCD});
        end
    endtask

    task automatic test_idle();
        drive_req(0, 1, 3'b010, 32'h0000_1234, 32'h0000_FFFF);
        n_cmp++;
        if ({ctl, MemAddr, ret} !== {7'b0000000, 32'h0000_1234, 34'h0}) begin
            n_bad++;
            $display("FAIL idle: got ctl=%b addr=%h ret=%h expected ctl=0 addr=00001234 ret=0", ctl, MemAddr, ret);
        end
    endtask

    task automatic test_back_to_back();
        drive_req(1, 0, 3'b010, 32'h0000_1000, 0);
        n_cmp++;
        if (ctl !== 7'b0011111) begin
            n_bad++;
            $display("FAIL b2b_lw_issue: got ctl=%b expected 0011111", ctl);
        end
        drive_req(1, 0, 3'b100, 32'h0000_1001, 0);
        n_cmp++;
        if ({ret, ctl} !== {2'b10, 32'hABCD_B2C3, 7'b0010010}) begin
            n_bad++;
            $display("FAIL b2b_lw_ret_lbu_issue: got ret=%h ctl=%b expected ret=%h ctl=0010010",
                     ret, ctl, {2'b10, 32'hABCD_B2C3});
        end
        drive_req(1, 1, 3'b000, 32'h0000_1001, 32'h0000_007E);
        n_cmp++;
        if (ret !== {2'b10, 32'h0000_00B2}) begin
            n_bad++;
            $display("FAIL b2b_lbu_ret: got %h expected %h", ret, {2'b10, 32'h0000_00B2});
        end
        n_cmp++;
        if ({ctl, MemWrData} !== {7'b0100010, 32'h0000_7E00}) begin
            n_bad++;
            $display("FAIL b2b_sb_issue: got ctl=%b wd=%h expected ctl=0100010 wd=00007e00", ctl, MemWrData);
        end
        drive_req(1, 0, 3'b010, 32'h0000_1000, 0);
        drive_req(0, 0, 3'b000, 32'h0000_1000, 0);
        n_cmp++;
        if (ret !== {2'b10, 32'hABCD_7EC3}) begin
            n_bad++;
            $display("FAIL b2b_sb_readback: got %h expected %h", ret, {2'b10, 32'hABCD_7EC3});
        end
    endtask

`ifndef RVC_LSU_MISALIGN_SPLIT_EN
    task automatic test_misalign_reject();
        drive_req(1, 0, 3'b010, 32'h0000_1002, 0);
        n_cmp++;
        if (ctl[6:4] !== 3'b000) begin
            n_bad++;
            $display("FAIL mis_lw_no_issue: got stall/wr/rd=%b expected 000", ctl[6:4]);
        end
        drive_req(1, 1, 3'b010, 32'h0000_1001, 32'h1111_1111);
        n_cmp++;
        if (ret !== {2'b11, 32'h0}) begin
            n_bad++;
            $display("FAIL mis_lw_err: got %h expected %h", ret, {2'b11, 32'h0});
        end
        n_cmp++;
        if (ctl[6:4] !== 3'b000) begin
            n_bad++;
            $display("FAIL mis_sw_no_issue: got stall/wr/rd=%b expected 000", ctl[6:4]);
        end
        drive_req(1, 0, 3'b001, 32'h0000_1003, 0);
        n_cmp++;
        if (ret !== {2'b01, 32'h0}) begin
            n_bad++;
            $display("FAIL mis_sw_err: got %h expected %h", ret, {2'b01, 32'h0});
        end
        drive_req(1, 0, 3'b001, 32'h0000_1002, 0);
        n_cmp++;
        if ({ret, ctl} !== {2'b11, 32'h0, 7'b0011100}) begin
            n_bad++;
            $display("FAIL mis_lh3_err_lh2_issue: got ret=%h ctl=%b expected ret=%h ctl=0011100",
                     ret, ctl, {2'b11, 32'h0});
        end
        drive_req(1, 0, 3'b010, 32'h0000_1000, 0);
        n_cmp++;
        if (ret !== {2'b10, 32'hFFFF_ABCD}) begin
            n_bad++;
            $display("FAIL lh_off2_ret: got %h expected %h", ret, {2'b10, 32'hFFFF_ABCD});
        end
        drive_req(0, 0, 3'b000, 32'h0000_1000, 0);
        n_cmp++;
        if (ret !== {2'b10, 32'hABCD_7EC3}) begin
            n_bad++;
            $display("FAIL mis_sw_no_write: got %h expected %h", ret, {2'b10, 32'hABCD_7EC3});
        end
        drive_req(0, 0, 3'b000, 32'h0000_1000, 0);
        n_cmp++;
        if (ret !== '0) begin
            n_bad++;
            $display("FAIL mis_err_pulse_end: got %h expected 0", ret);
        end
    endtask
`endif

`ifdef RVC_LSU_MISALIGN_SPLIT_EN
    task automatic test_split_load();
        preload(4'd0, 32'h4433_2211);
        preload(4'd1, 32'h8877_6655);
        drive_req(1, 0, 3'b010, 32'h0000_1001, 0);
        n_cmp++;
        if ({ctl, MemAddr} !== {7'b1011110, 32'h0000_1000}) begin
            n_bad++;
            $display("FAIL split_lw_first: got ctl=%b addr=%h expected ctl=1011110 addr=00001000", ctl, MemAddr);
        end
        hold_cycle();
        n_cmp++;
        if ({ctl, MemAddr, ret} !== {7'b0010001, 32'h0000_1004, 34'h0}) begin
            n_bad++;
            $display("FAIL split_lw_second: got ctl=%b addr=%h ret=%h expected ctl=0010001 addr=00001004 ret=0",
                     ctl, MemAddr, ret);
        end
        drive_req(1, 0, 3'b010, 32'h0000_1004, 0);
        n_cmp++;
        if (ret !== {2'b10, 32'h5544_3322}) begin
            n_bad++;
            $display("FAIL split_lw_merge: got %h expected %h", ret, {2'b10, 32'h5544_3322});
        end
        n_cmp++;
        if ({ctl, MemAddr} !== {7'b0011111, 32'h0000_1004}) begin
            n_bad++;
            $display("FAIL split_b2b_issue: got ctl=%b addr=%h expected ctl=0011111 addr=00001004", ctl, MemAddr);
        end
        drive_req(0, 0, 3'b000, 32'h0000_1004, 0);
        n_cmp++;
        if (ret !== {2'b10, 32'h8877_6655}) begin
            n_bad++;
            $display("FAIL split_b2b_ret: got %h expected %h", ret, {2'b10, 32'h8877_6655});
        end
    endtask

    task automatic test_split_store();
        drive_req(1, 1, 3'b010, 32'h0000_1003, 32'hA1B2_C3D4);
        n_cmp++;
        if ({ctl, MemAddr, MemWrData} !== {7'b1101000, 32'h0000_1000, 32'hD400_0000}) begin
            n_bad++;
            $display("FAIL split_sw_first: got ctl=%b addr=%h wd=%h expected 1101000 00001000 d4000000",
                     ctl, MemAddr, MemWrData);
        end
        hold_cycle();
        n_cmp++;
        if ({ctl, MemAddr, MemWrData} !== {7'b0100111, 32'h0000_1004, 32'h00A1_B2C3}) begin
            n_bad++;
            $display("FAIL split_sw_second: got ctl=%b addr=%h wd=%h expected 0100111 00001004 00a1b2c3",
                     ctl, MemAddr, MemWrData);
        end
        drive_req(1, 0, 3'b010, 32'h0000_1000, 0);
        n_cmp++;
        if (ret !== '0) begin
            n_bad++;
            $display("FAIL split_sw_no_ldvalid: got %h expected 0", ret);
        end
        drive_req(1, 0, 3'b010, 32'h0000_1004, 0);
        n_cmp++;
        if (ret !== {2'b10, 32'hD433_2211}) begin
            n_bad++;
            $display("FAIL split_sw_low: got %h expected %h", ret, {2'b10, 32'hD433_2211});
        end
        drive_req(1, 1, 3'b010, 32'hFFFF_FFFE, 32'h1234_5678);
        n_cmp++;
        if (ret !== {2'b10, 32'h88A1_B2C3}) begin
            n_bad++;
            $display("FAIL split_sw_high: got %h expected %h", ret, {2'b10, 32'h88A1_B2C3});
        end
        n_cmp++;
        if ({ctl, MemAddr, MemWrData} !== {7'b1101100, 32'hFFFF_FFFC, 32'h5678_0000}) begin
            n_bad++;
            $display("FAIL wrap_first: got ctl=%b addr=%h wd=%h expected 1101100 fffffffc 56780000",
                     ctl, MemAddr, MemWrData);
        end
        hold_cycle();
        n_cmp++;
        if ({ctl, MemAddr, MemWrData} !== {7'b0100011, 32'h0000_0000, 32'h0000_1234}) begin
            n_bad++;
            $display("FAIL wrap_second: got ctl=%b addr=%h wd=%h expected 0100011 00000000 00001234",
                     ctl, MemAddr, MemWrData);
        end
        drive_req(0, 0, 3'b000, 32'h0000_1000, 0);
    endtask

    task automatic test_split_reset();
        drive_req(1, 0, 3'b010, 32'h0000_1001, 0);
        @(negedge Clock);
        Rst = 1'b1;
        #1;
        n_cmp++;
        if ({ctl, MemAddr, MemWrData, ret} !== '0) begin
            n_bad++;
            $display("FAIL split_reset_outputs: got ctl=%b addr=%h wd=%h ret=%h expected all zero",
                     ctl, MemAddr, MemWrData, ret);
        end
        @(negedge Clock);
        Rst = 1'b0;
        drive_req(1, 0, 3'b010, 32'h0000_1000, 0);
        n_cmp++;
        if ({ctl, MemAddr, ret} !== {7'b0011111, 32'h0000_1000, 34'h0}) begin
            n_bad++;
            $display("FAIL split_reset_idle: got ctl=%b addr=%h ret=%h expected ctl=0011111 addr=00001000 ret=0",
                     ctl, MemAddr, ret);
        end
        drive_req(0, 0, 3'b000, 32'h0000_1000, 0);
    endtask
`endif

    task automatic test_reset_async();
        preload(4'd0, 32'h0BAD_F00D);
        drive_req(1, 0, 3'b010, 32'h0000_1000, 0);
        drive_req(1, 0, 3'b010, 32'h0000_1000, 0);
        n_cmp++;
        if (ret !== {2'b10, 32'h0BAD_F00D}) begin
            n_bad++;
            $display("FAIL async_pre: got %h expected %h", ret, {2'b10, 32'h0BAD_F00D});
        end
        Rst = 1'b1;
        #1;
        n_cmp++;
        if ({ctl, MemAddr, ret} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got ctl=%b addr=%h ret=%h expected all zero", ctl, MemAddr, ret);
        end
        @(negedge Clock);
        ReqValidQ103H = 1'b0;
        Rst = 1'b0;
        drive_req(0, 0, 3'b000, 32'h0000_1000, 0);
        n_cmp++;
        if (ret !== '0) begin
            n_bad++;
            $display("FAIL async_no_result: got %h expected 0", ret);
        end
    endtask

    initial begin
        test_reset();
        test_aligned_lw();
        test_byte_load();
        test_store_half();
        test_idle();
        test_back_to_back();
`ifndef RVC_LSU_MISALIGN_SPLIT_EN
        test_misalign_reject();
`endif
`ifdef RVC_LSU_MISALIGN_SPLIT_EN
        test_split_load();
        test_split_store();
        test_split_reset();
`endif
        test_reset_async();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
